// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_pkg
//  Description : Shared constants and helpers for the NTT datapath.
//                C_WIDTH       - modular operand/result width in bits
//                C_MUL_LATENCY - default modular multiplier latency
//                                (operand register + product + reduction)
//                clog2()       - ceiling log2 for elaboration-time sizing
//                tag_width()   - requester tag width, never below one bit
//  Revision    : 1.0 - initial release
// ============================================================================
package ntt_pkg;

    localparam int C_WIDTH       = 30;
    localparam int C_MUL_LATENCY = 5;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // A single requester still needs a one-bit tag field.
    function automatic int tag_width(input int num_req);
        return (clog2(num_req) < 1) ? 1 : clog2(num_req);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin grant. Picks the first asserted
//                request searching upward from ptr, wrapping modulo NUM_REQ.
//                The pointer register belongs to the parent.
//  Ports       : req       in  NUM_REQ  request vector
//                ptr       in  TAG_W    highest-priority requester index
//                grant     out NUM_REQ  one-hot grant (zero if no request)
//                grant_idx out TAG_W    binary index of the grant (0 if none)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import ntt_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]            req,
    input  logic [tag_width(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]            grant,
    output logic [tag_width(NUM_REQ)-1:0] grant_idx
);

    localparam int TAG_W = tag_width(NUM_REQ);

    int   w_idx;
    logic w_found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(ptr) + k) % NUM_REQ;
            if (!w_found && req[w_idx]) begin
                w_found      = 1'b1;
                grant[w_idx] = 1'b1;
                grant_idx    = TAG_W'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mod_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mod_mul_arbiter
//  Description : Shares one pipelined modular multiplier (no valid/stall of
//                its own) among NUM_REQ requesters. Round-robin issue of at
//                most one operand pair per cycle; a {valid, tag} delay line
//                matched to the multiplier latency steers each result back.
//  Ports       : clk, rst_n            clock, synchronous active-low reset
//                req_valid/req_ready   per-requester handshake (ready one-hot)
//                req_a/req_b           packed operands, requester i at
//                                      [i*WIDTH +: WIDTH]
//                mul_a/mul_b           registered operands to the multiplier
//                mul_c                 multiplier result
//                rsp_valid/rsp_data    one-hot owner of the result, result
//                busy                  any operation in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_mul_arbiter
    import ntt_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = C_MUL_LATENCY,
    parameter int WIDTH       = C_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [WIDTH-1:0]           mul_a,
    output logic [WIDTH-1:0]           mul_b,
    input  logic [WIDTH-1:0]           mul_c,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]           rsp_data,
    output logic                       busy
);

    localparam int TAG_W   = tag_width(NUM_REQ);
    // One extra entry covers the mul_a/mul_b register in front of the
    // multiplier's own MUL_LATENCY stages.
    localparam int C_DEPTH = MUL_LATENCY + 1;

    logic [TAG_W-1:0]   r_ptr;
    logic [C_DEPTH-1:0] r_vld;
    logic [TAG_W-1:0]   r_tag [C_DEPTH];

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_grant;
    logic [TAG_W-1:0]   w_grant_idx;
    logic [TAG_W-1:0]   w_ptr_next;
    logic               w_xfer;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;

    // No grants while reset is held, so nothing is accepted that would be lost.
    assign w_req = rst_n ? req_valid : '0;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ)
    ) u_rr_arbiter (
        .req       (w_req),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    assign req_ready  = w_grant;
    assign w_xfer     = |w_grant;
    assign w_sel_a    = req_a[int'(w_grant_idx) * WIDTH +: WIDTH];
    assign w_sel_b    = req_b[int'(w_grant_idx) * WIDTH +: WIDTH];
    assign w_ptr_next = (w_grant_idx == TAG_W'(NUM_REQ - 1)) ? '0
                                                              : w_grant_idx + TAG_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
            mul_a <= '0;
            mul_b <= '0;
            r_vld <= '0;
        end else begin
            if (w_xfer) begin
                r_ptr <= w_ptr_next;
                mul_a <= w_sel_a;
                mul_b <= w_sel_b;
            end
            r_vld <= {r_vld[C_DEPTH-2:0], w_xfer};
        end
    end

    // Tags are only meaningful alongside their valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        r_tag[0] <= w_grant_idx;
        for (int j = 1; j < C_DEPTH; j++) begin
            r_tag[j] <= r_tag[j-1];
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
        assign rsp_valid[gi] = rst_n & r_vld[C_DEPTH-1] & (r_tag[C_DEPTH-1] == TAG_W'(gi));
    end

    assign rsp_data = mul_c;
    assign busy     = rst_n & (|r_vld);

endmodule
`default_nettype wire

// File: tb/tb_mod_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_mul_arbiter
//  Description : Self-checking bench for mod_mul_arbiter with a fixed-latency
//                modular multiplier model and a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_mul_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int MUL_LATENCY = 5;
    localparam int WIDTH       = 30;
    localparam longint unsigned Q = 64'd998244353;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ*WIDTH-1:0] req_a = '0;
    logic [NUM_REQ*WIDTH-1:0] req_b = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]         mul_a;
    logic [WIDTH-1:0]         mul_b;
    logic [WIDTH-1:0]         mul_c;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]         rsp_data;
    logic                     busy;

    always #5 clk = ~clk;

    mod_mul_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .MUL_LATENCY (MUL_LATENCY),
        .WIDTH       (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_c     (mul_c),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    function automatic logic [WIDTH-1:0] modmul(input longint unsigned a, input longint unsigned b);
        return WIDTH'((a * b) % Q);
    endfunction

    // Multiplier model: MUL_LATENCY stages from mul_a/mul_b to mul_c, not reset.
    bit [WIDTH-1:0] mpipe [MUL_LATENCY];
    always @(posedge clk) begin
        mpipe[0] <= modmul(longint'(mul_a), longint'(mul_b));
        for (int j = 1; j < MUL_LATENCY; j++) mpipe[j] <= mpipe[j-1];
    end
    assign mul_c = mpipe[MUL_LATENCY-1];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model and compare process ----------------
    typedef struct {
        int             tag;
        logic [WIDTH-1:0] data;
        int             due;
    } op_t;

    op_t sb[$];
    int  m_ptr = 0;
    int  cyc = 0;
    int  wait_cnt [NUM_REQ];
    logic [NUM_REQ-1:0] last_xfer = '0;

    int grant_log[$];
    int grant_cyc[$];
    int rsp_tag_log[$];
    int rsp_data_log[$];
    int rsp_cyc_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    always @(negedge clk) begin
        logic [NUM_REQ-1:0] exp_rv;
        logic [NUM_REQ-1:0] exp_ready;
        int g;
        int idx;
        op_t op;

        if (req_ready != '0) begin
            grant_log.push_back(onehot_idx(req_ready));
            grant_cyc.push_back(cyc);
        end
        if (rsp_valid != '0) begin
            rsp_tag_log.push_back(onehot_idx(rsp_valid));
            rsp_data_log.push_back(int'(rsp_data));
            rsp_cyc_log.push_back(cyc);
        end
        last_xfer = req_ready & req_valid;

        if (!rst_n) begin
            chk("rst_ready", longint'(req_ready), 0);
            chk("rst_rsp_valid", longint'(rsp_valid), 0);
            chk("rst_busy", longint'(busy), 0);
            sb.delete();
            m_ptr = 0;
            for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] = 0;
        end else begin
            exp_rv = '0;
            chk("busy", longint'(busy), longint'(sb.size() > 0));
            if (sb.size() > 0 && sb[0].due == cyc) begin
                op = sb.pop_front();
                exp_rv[op.tag] = 1'b1;
                chk("rsp_data", longint'(rsp_data), longint'(op.data));
            end
            chk("rsp_valid", longint'(rsp_valid), longint'(exp_rv));

            g = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (m_ptr + k) % NUM_REQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            chk("req_ready", longint'(req_ready), longint'(exp_ready));

            if (g >= 0) begin
                op.tag  = g;
                op.data = modmul(longint'(req_a[g*WIDTH +: WIDTH]), longint'(req_b[g*WIDTH +: WIDTH]));
                op.due  = cyc + MUL_LATENCY + 1;
                sb.push_back(op);
                m_ptr = (g + 1) % NUM_REQ;
                chk("starvation", longint'(wait_cnt[g] <= NUM_REQ - 1), 1);
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (i == g || !req_valid[i]) wait_cnt[i] = 0;
                    else wait_cnt[i] = wait_cnt[i] + 1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_valid[i]             = v;
        req_a[i*WIDTH +: WIDTH]  = a;
        req_b[i*WIDTH +: WIDTH]  = b;
    endtask

    task automatic apply_reset();
        req_valid = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int n0;
        int g0;
        int r0;
        int p;

        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        // Idle after reset: nothing granted, nothing in flight.
        for (int c = 0; c < 20; c++) begin
            step();
            if (c == 0 || c == 19) begin
                chk("idle_mul_a", longint'(mul_a), 0);
                chk("idle_mul_b", longint'(mul_b), 0);
                chk("idle_busy", longint'(busy), 0);
            end
        end

        // Single op from requester 2: 3*5.
        set_req(2, 1'b1, 30'd3, 30'd5);
        #3;
        chk("single_ready", longint'(req_ready), 4'b0100);
        step();
        req_valid = '0;
        repeat (4) step();
        chk("single_early", longint'(rsp_valid), 0);
        step();
        chk("single_rsp_valid", longint'(rsp_valid), 4'b0100);
        chk("single_rsp_data", longint'(rsp_data), 15);
        chk("single_busy_hi", longint'(busy), 1);
        step();
        chk("single_busy_lo", longint'(busy), 0);

        // All four requesters for 8 cycles.
        apply_reset();
        g0 = grant_log.size();
        r0 = rsp_data_log.size();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, WIDTH'(i + 1), 30'd10);
        repeat (8) step();
        req_valid = '0;
        repeat (10) step();
        chk("burst_grants", longint'(grant_log.size() - g0), 8);
        chk("burst_rsps", longint'(rsp_data_log.size() - r0), 8);
        if (grant_log.size() - g0 >= 8 && rsp_data_log.size() - r0 >= 8) begin
            for (int k = 0; k < 8; k++) begin
                chk("burst_grant_order", longint'(grant_log[g0 + k]), k % 4);
                chk("burst_rsp_data", longint'(rsp_data_log[r0 + k]), (k % 4 + 1) * 10);
                chk("burst_rsp_tag", longint'(rsp_tag_log[r0 + k]), k % 4);
                if (k > 0) chk("burst_b2b", longint'(rsp_cyc_log[r0 + k] - rsp_cyc_log[r0 + k - 1]), 1);
            end
        end

        // Pointer at 2 with requesters 1 and 3 pending.
        apply_reset();
        set_req(1, 1'b1, 30'd7, 30'd9);
        step();
        req_valid = '0;
        set_req(1, 1'b1, 30'd11, 30'd13);
        set_req(3, 1'b1, 30'd17, 30'd19);
        #3;
        chk("wrap_first", longint'(req_ready), 4'b1000);
        step();
        req_valid[3] = 1'b0;
        #3;
        chk("wrap_second", longint'(req_ready), 4'b0010);
        step();
        req_valid = '0;
        repeat (10) step();

        // Reset with three ops in flight.
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            set_req(0, 1'b1, WIDTH'(k + 2), 30'd100);
            step();
        end
        req_valid = '0;
        step();
        chk("flush_busy_pre", longint'(busy), 1);
        step();
        n0 = rsp_data_log.size();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (12) step();
        chk("flush_no_rsp", longint'(rsp_data_log.size() - n0), 0);
        chk("flush_busy", longint'(busy), 0);

        // Randomised traffic; requesters hold valid until accepted.
        for (int c = 0; c < 10000; c++) begin
            p = (c < 5000) ? 35 : 90;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || last_xfer[i]) begin
                    if ($urandom_range(99) < p)
                        set_req(i, 1'b1, WIDTH'($urandom), WIDTH'($urandom));
                    else
                        req_valid[i] = 1'b0;
                end
            end
            rst_n = ($urandom_range(2999) != 0);
            step();
        end
        rst_n = 1'b1;
        req_valid = '0;
        repeat (20) step();
        chk("drain_empty", longint'(sb.size()), 0);
        chk("drain_busy", longint'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
